// File: rtl/mac_pkg.sv
// Shared types and constants for the MAC transmit frame builder.
// Padding support is selected in the top module with MAC_TX_PAD_EN.
package mac_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HDR     = 2'd1,
        PAYLOAD = 2'd2,
        PAD     = 2'd3
    } mac_state_t;

    localparam int         MAC_HDR_LEN     = 14;
    localparam int         MAC_MIN_PAYLOAD = 46;
    localparam logic [7:0] MAC_PAD_BYTE    = 8'h00;

endpackage

// File: rtl/mac_tx_frame_builder.sv
// Builds an Ethernet frame (dst, src, type, payload, optional pad) ahead of CRC insertion.
// Define MAC_TX_PAD_EN to pad short payloads to the 46-byte minimum.
module mac_tx_frame_builder
    import mac_pkg::*;
#(
    parameter logic [47:0] LOCAL_MAC = 48'hABCD_1234_5678
) (
    input  logic        logic_clk,
    input  logic        logic_rst,
    input  logic [7:0]  net_data_in,
    input  logic        net_valid_in,
    output logic        net_ready_out,
    input  logic        net_last_in,
    input  logic [47:0] net_dst_mac_in,
    input  logic [15:0] net_type_in,
    output logic [7:0]  mac_data_out,
    output logic        mac_valid_out,
    input  logic        mac_ready_in,
    output logic        mac_last_out
);

    localparam logic [3:0] HDR_LAST = 4'(MAC_HDR_LEN - 1);

    mac_state_t    r_state;
    logic [47:0]   r_dst;
    logic [15:0]   r_type;
    logic [3:0]    r_idx;

    logic          w_out_acc;
    logic          w_pay_last;
    logic          w_pad_last;
    logic [111:0]  w_hdr_vec;
    logic [111:0]  w_hdr_shift;
    logic [7:0]    w_hdr_byte;

`ifdef MAC_TX_PAD_EN
    localparam logic [5:0] MIN_PAY     = 6'(MAC_MIN_PAYLOAD);
    localparam logic [5:0] MIN_PAY_M1  = 6'(MAC_MIN_PAYLOAD - 1);

    logic [5:0] r_cnt;

    // r_cnt counts bytes already accepted, so the current byte is number r_cnt+1
    assign w_pay_last = (r_cnt >= MIN_PAY_M1);
    assign w_pad_last = (r_cnt == MIN_PAY_M1);
`else
    assign w_pay_last = 1'b1;
    assign w_pad_last = 1'b0;
`endif

    // Header byte select: index 0 is the dst MAC MSB, index 13 the type LSB
    assign w_hdr_vec   = {r_dst, LOCAL_MAC, r_type};
    assign w_hdr_shift = w_hdr_vec >> {(HDR_LAST - r_idx), 3'b000};
    assign w_hdr_byte  = w_hdr_shift[7:0];

    assign w_out_acc = mac_valid_out && mac_ready_in;

    always_comb begin
        mac_data_out  = 8'h00;
        mac_valid_out = 1'b0;
        mac_last_out  = 1'b0;
        net_ready_out = 1'b0;
        case (r_state)
            HDR: begin
                mac_data_out  = w_hdr_byte;
                mac_valid_out = 1'b1;
            end
            PAYLOAD: begin
                mac_data_out  = net_data_in;
                mac_valid_out = net_valid_in;
                mac_last_out  = net_last_in && w_pay_last;
                net_ready_out = mac_ready_in;
            end
            PAD: begin
                mac_data_out  = MAC_PAD_BYTE;
                mac_valid_out = 1'b1;
                mac_last_out  = w_pad_last;
            end
            default: ;
        endcase
    end

    always_ff @(posedge logic_clk or posedge logic_rst) begin
        if (logic_rst) begin
            r_state <= IDLE;
            r_dst   <= '0;
            r_type  <= '0;
            r_idx   <= '0;
`ifdef MAC_TX_PAD_EN
            r_cnt   <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (net_valid_in) begin
                        r_dst   <= net_dst_mac_in;
                        r_type  <= net_type_in;
                        r_idx   <= '0;
`ifdef MAC_TX_PAD_EN
                        r_cnt   <= '0;
`endif
                        r_state <= HDR;
                    end
                end
                HDR: begin
                    if (w_out_acc) begin
                        if (r_idx == HDR_LAST) begin
                            r_state <= PAYLOAD;
                        end else begin
                            r_idx <= r_idx + 4'd1;
                        end
                    end
                end
                PAYLOAD: begin
                    if (w_out_acc) begin
`ifdef MAC_TX_PAD_EN
                        if (r_cnt != MIN_PAY) begin
                            r_cnt <= r_cnt + 6'd1;
                        end
                        if (net_last_in) begin
                            r_state <= w_pay_last ? IDLE : PAD;
                        end
`else
                        if (net_last_in) begin
                            r_state <= IDLE;
                        end
`endif
                    end
                end
                PAD: begin
`ifdef MAC_TX_PAD_EN
                    if (w_out_acc) begin
                        r_cnt <= r_cnt + 6'd1;
                        if (w_pad_last) begin
                            r_state <= IDLE;
                        end
                    end
`else
                    r_state <= IDLE;
`endif
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_tx_frame_builder.sv
// Scoreboard bench for mac_tx_frame_builder; follows MAC_TX_PAD_EN like the design.
`timescale 1ns/1ps
module tb_mac_tx_frame_builder;

    localparam logic [47:0] LMAC     = 48'hABCD_1234_5678;
    localparam int          MIN_PAY  = 46;
`ifdef MAC_TX_PAD_EN
    localparam bit          PAD_EN   = 1'b1;
`else
    localparam bit          PAD_EN   = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  net_data_in = 8'h00;
    logic        net_valid_in = 1'b0;
    logic        net_ready_out;
    logic        net_last_in = 1'b0;
    logic [47:0] net_dst_mac_in = '0;
    logic [15:0] net_type_in = '0;
    logic [7:0]  mac_data_out;
    logic        mac_valid_out;
    logic        mac_ready_in = 1'b1;
    logic        mac_last_out;

    int total = 0;
    int bad   = 0;
    int ready_mode = 0;
    logic [8:0] exp_q[$];

    always #5 clk = ~clk;

    mac_tx_frame_builder #(.LOCAL_MAC(LMAC)) dut (
        .logic_clk      (clk),
        .logic_rst      (rst),
        .net_data_in    (net_data_in),
        .net_valid_in   (net_valid_in),
        .net_ready_out  (net_ready_out),
        .net_last_in    (net_last_in),
        .net_dst_mac_in (net_dst_mac_in),
        .net_type_in    (net_type_in),
        .mac_data_out   (mac_data_out),
        .mac_valid_out  (mac_valid_out),
        .mac_ready_in   (mac_ready_in),
        .mac_last_out   (mac_last_out)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [47:0] rnd48();
        logic [47:0] v;
        v[47:16] = $urandom();
        v[15:0]  = 16'($urandom());
        return v;
    endfunction

    // Downstream ready pattern: 0 always ready, 1 alternate, 2 random
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       mac_ready_in = 1'b1;
                1:       mac_ready_in = ~mac_ready_in;
                default: mac_ready_in = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: every accepted output byte is compared with the scoreboard head
    initial begin
        logic       prev_st;
        logic [8:0] prev;
        logic [8:0] e;
        prev_st = 1'b0;
        prev    = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("rst_valid", 64'(mac_valid_out), 64'd0);
                chk("rst_last",  64'(mac_last_out),  64'd0);
                chk("rst_data",  64'(mac_data_out),  64'd0);
                chk("rst_ready", 64'(net_ready_out), 64'd0);
                prev_st = 1'b0;
            end else if (mac_valid_out) begin
                if (prev_st)
                    chk("stall_hold", 64'({mac_data_out, mac_last_out}), 64'(prev));
                if (mac_ready_in) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_byte actual=%h required=none at %0t",
                                 {mac_data_out, mac_last_out}, $time);
                    end else begin
                        e = exp_q.pop_front();
                        chk("frame_byte{data,last}", 64'({mac_data_out, mac_last_out}), 64'(e));
                    end
                    prev_st = 1'b0;
                end else begin
                    prev_st = 1'b1;
                    prev    = {mac_data_out, mac_last_out};
                end
            end else begin
                prev_st = 1'b0;
            end
        end
    end

    // Reference: header, payload, zero pad up to the minimum, last on final byte
    task automatic push_expected(input logic [47:0] dst, input logic [15:0] typ,
                                 input logic [7:0] pl[$]);
        logic [7:0] bytes[$];
        int plen;
        for (int i = 5; i >= 0; i--) bytes.push_back(dst[i*8 +: 8]);
        for (int i = 5; i >= 0; i--) bytes.push_back(LMAC[i*8 +: 8]);
        bytes.push_back(typ[15:8]);
        bytes.push_back(typ[7:0]);
        foreach (pl[i]) bytes.push_back(pl[i]);
        plen = (PAD_EN && pl.size() < MIN_PAY) ? MIN_PAY : pl.size();
        for (int i = pl.size(); i < plen; i++) bytes.push_back(8'h00);
        foreach (bytes[i]) exp_q.push_back({bytes[i], (i == bytes.size() - 1)});
    endtask

    task automatic send_frame(input logic [47:0] dst, input logic [15:0] typ,
                              input int len, input bit seq, input int abort_at);
        logic [7:0] pl[$];
        bit got;
        for (int i = 0; i < len; i++) pl.push_back(seq ? 8'(i) : 8'($urandom()));
        push_expected(dst, typ, pl);
        net_dst_mac_in = dst;
        net_type_in    = typ;
        for (int i = 0; i < len; i++) begin
            net_valid_in = 1'b1;
            net_data_in  = pl[i];
            net_last_in  = (i == len - 1);
            if (i == abort_at) begin
                exp_q.delete();
                rst = 1'b1;
                net_valid_in = 1'b0;
                net_last_in  = 1'b0;
                repeat (2) @(posedge clk);
                #1;
                rst = 1'b0;
                return;
            end
            got = 1'b0;
            for (int t = 0; t < 400 && !got; t++) begin
                @(negedge clk);
                got = net_ready_out;
                @(posedge clk);
                #1;
            end
            if (!got) begin
                total++;
                bad++;
                $display("FAIL in_accept_timeout actual=not_accepted required=accepted byte=%0d", i);
                net_valid_in = 1'b0;
                return;
            end
            // Header fields must already be captured; scramble them mid-frame
            if (i == 0) begin
                net_dst_mac_in = rnd48();
                net_type_in    = 16'($urandom());
            end
        end
        net_valid_in = 1'b0;
        net_last_in  = 1'b0;
        for (int t = 0; t < 1000 && exp_q.size() > 0; t++) begin
            @(posedge clk);
            #1;
        end
        if (exp_q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout actual=%0d required=0 pending bytes", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        ready_mode = 0;
        send_frame(48'h0102_0304_0506, 16'h0800, 50, 1'b1, -1);
        send_frame(48'h0102_0304_0506, 16'h0800, 10, 1'b1, -1);
        ready_mode = 1;
        send_frame(48'h0102_0304_0506, 16'h0800, 10, 1'b1, -1);
        ready_mode = 0;
        send_frame(rnd48(), 16'h86DD, 46, 1'b0, -1);
        send_frame(rnd48(), 16'h0806, 47, 1'b0, -1);
        send_frame(rnd48(), 16'h0800, 45, 1'b0, -1);
        send_frame(rnd48(), 16'h0800, 1, 1'b0, -1);
        send_frame(rnd48(), 16'h0800, 20, 1'b1, 4);
        send_frame(48'h0102_0304_0506, 16'h0800, 12, 1'b1, -1);

        for (int f = 0; f < 25; f++) begin
            ready_mode = int'($urandom_range(0, 2));
            send_frame(rnd48(), 16'($urandom()), int'($urandom_range(1, 60)), 1'b0, -1);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end

        ready_mode = 0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("final_idle_valid", 64'(mac_valid_out), 64'd0);
        chk("final_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mac_tx_frame_builder.md
MAC_TX_FRAME_BUILDER -- requirements
Module: mac_tx_frame_builder

Interface
REQ-001 SHALL have parameter LOCAL_MAC, default 48'hABCD_1234_5678, source MAC inserted in every frame.
REQ-002 SHALL have port logic_clk  input  1  sole clock; one clock, all logic on rising edge.
REQ-003 SHALL have port logic_rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port net_data_in  input  8  payload byte from upper layer.
REQ-005 SHALL have port net_valid_in  input  1  payload byte valid.
REQ-006 SHALL have port net_ready_out  output  1  payload byte accepted when high with net_valid_in.
REQ-007 SHALL have port net_last_in  input  1  final payload byte of frame.
REQ-008 SHALL have port net_dst_mac_in  input  48  destination MAC, sampled at frame start.
REQ-009 SHALL have port net_type_in  input  16  EtherType, sampled at frame start.
REQ-010 SHALL have port mac_data_out  output  8  frame byte to MAC tx path (CRC appended downstream).
REQ-011 SHALL have port mac_valid_out  output  1  frame byte valid.
REQ-012 SHALL have port mac_ready_in  input  1  downstream accepts byte.
REQ-013 SHALL have port mac_last_out  output  1  final byte of frame (pre-CRC).

Function
REQ-014 SHALL implement FSM states IDLE, HDR, PAYLOAD, PAD.
REQ-015 IDLE: net_ready_out=0, mac_valid_out=0; on net_valid_in=1, latch net_dst_mac_in/net_type_in, clear counters, go HDR next cycle.
REQ-016 HDR: emit 14 registered bytes, MSB first: dst MAC[47:40]..[7:0], LOCAL_MAC[47:40]..[7:0], type[15:8], type[7:0]; 4-bit index advances only on mac_valid_out&&mac_ready_in; after byte 13 accepted go PAYLOAD.
REQ-017 PAYLOAD: zero-latency pass-through; mac_data_out=net_data_in, mac_valid_out=net_valid_in, net_ready_out=mac_ready_in.
REQ-018 Payload counter SHALL be 6 bits, increment per accepted payload byte, saturate at 46.
REQ-019 On accepted byte with net_last_in=1: if count incl. this byte >=46 (or padding compiled out), mac_last_out=1 on that byte, go IDLE; else mac_last_out=0, go PAD.
REQ-020 PAD: net_ready_out=0; emit registered 0x00 bytes until total payload+pad=46; mac_last_out=1 on 46th byte; then IDLE.
REQ-021 mac_data_out/mac_last_out SHALL hold stable while mac_valid_out=1 and mac_ready_in=0.
REQ-022 Zero-length payload (first accepted byte not possible) SHALL NOT occur: frame start requires net_valid_in, payload >=1 byte.
REQ-023 Back-to-back frames: IDLE SHALL accept next frame start in the cycle after last byte accepted (one idle cycle minimum).
REQ-024 net_dst_mac_in/net_type_in changes after frame start SHALL NOT affect the current frame.

Reset
REQ-025 On logic_rst: state IDLE, counters 0, mac_data_out=0x00, mac_valid_out=0, mac_last_out=0, net_ready_out=0, latched dst/type 0.
REQ-026 Reset mid-frame SHALL abort immediately with no mac_last_out emitted; downstream tolerates truncated frame.

Configuration
REQ-027 Macro MAC_TX_PAD_EN defined: PAD state and padding to 46 payload bytes active.
REQ-028 MAC_TX_PAD_EN undefined: PAD state and saturating counter removed; mac_last_out always asserted on the byte with net_last_in.

Structure
REQ-029 Package mac_pkg SHALL hold FSM state typedef, MAC_HDR_LEN=14, MAC_MIN_PAYLOAD=46, MAC_PAD_BYTE=8'h00.
REQ-030 Single module, no sub-module; header byte select is a local mux.

Verification
REQ-031 dst=48'h0102_0304_0506, type=16'h0800, 50-byte payload 0x00..0x31, ready=1 -> 64 bytes out: 01..06, AB CD 12 34 56 78, 08 00, payload; last on byte 64.
REQ-032 10-byte payload, MAC_TX_PAD_EN defined -> 14 hdr + 10 payload + 36 bytes 0x00; last on byte 60.
REQ-033 Same 10-byte frame, MAC_TX_PAD_EN undefined -> 24 bytes; last on byte 24.
REQ-034 mac_ready_in toggled 1/0 each cycle during HDR/PAYLOAD/PAD -> byte sequence identical to REQ-032, outputs stable while stalled.
REQ-035 46-byte payload -> no pad, last on payload byte 46; 47-byte payload -> last on byte 47.
REQ-036 logic_rst asserted at payload byte 5 -> next cycle mac_valid_out=0, no last; following frame output fully correct from byte 1.
